arith_stream_unit: RTL

Sequential, handshake-driven signed arithmetic responder. It accepts one operation request (A, B, op select) on a valid/ready input channel and returns the result and an overflow flag on a valid/ready output channel. Add, subtract and negate complete in one cycle; multiply runs as an iterative shift-add over WIDTH cycles. The block is the responding end of the operand stream that benches and upstream sequencers drive into the arithmetic datapath.

---
 rtl/arith_pkg.sv | 30 +++
 rtl/arith_seq_mul.sv | 74 +++++++
 rtl/arith_stream_unit.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arith_pkg
// Description : Shared op/state encodings and counter helper for arith_stream_unit
// Revision    : 1.0 - initial release
// ============================================================================
package arith_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_NEG = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam int OVF_CNT_W = 8;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [OVF_CNT_W-1:0] sat_inc(input logic [OVF_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arith_seq_mul.sv
`default_nettype none
// ============================================================================
// Module      : arith_seq_mul
// Description : Signed shift-add multiplier, one partial product per cycle,
//               result valid WIDTH cycles after start (done pulses for 1 cycle)
// Revision    : 1.0 - initial release
// ============================================================================
module arith_seq_mul #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int              c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_busy;
    logic               r_done;

    logic [2*WIDTH-1:0] w_a_ext;
    logic               w_last;
    logic [2*WIDTH-1:0] w_addend;

    assign w_a_ext = {{WIDTH{a[WIDTH-1]}}, a};
    assign w_last  = (r_cnt == c_LAST);

    // Bit WIDTH-1 of B carries negative weight, so its partial product is subtracted.
    assign w_addend = r_mplier[0] ? (w_last ? -r_mcand : r_mcand) : '0;

    // Bit 0 is folded into the start cycle, leaving WIDTH-1 iterative steps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_acc    <= b[0] ? w_a_ext : '0;
                r_mcand  <= w_a_ext << 1;
                r_mplier <= b >> 1;
                r_cnt    <= c_CNT_W'(1);
                r_busy   <= 1'b1;
            end else if (r_busy) begin
                r_acc    <= r_acc + w_addend;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + 1'b1;
                if (w_last) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign done    = r_done;
    assign product = r_acc;

endmodule
`default_nettype wire

// File: rtl/arith_stream_unit.sv
`default_nettype none
// ============================================================================
// Module      : arith_stream_unit
// Description : Valid/ready signed add/sub/mul/neg responder with overflow flag.
//               Optional saturating overflow counter: ARITH_OVF_COUNT_EN
// Revision    : 1.0 - initial release
// ============================================================================
module arith_stream_unit
    import arith_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [1:0]           sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     q,
`ifdef ARITH_OVF_COUNT_EN
    output logic [OVF_CNT_W-1:0] ovf_count,
`endif
    output logic                 overflow
);

    state_e r_state;
    state_e w_next;

    logic               r_in_ready;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_q;
    logic               r_ov;

    op_e                w_op;
    logic               w_accept;
    logic               w_mul_start;
    logic [WIDTH:0]     w_a_ext;
    logic [WIDTH:0]     w_b_ext;
    logic [WIDTH:0]     w_wide;
    logic [WIDTH-1:0]   w_fast_q;
    logic               w_fast_ov;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH:0]     w_prod_hi;
    logic               w_mul_ov;

    assign w_op        = op_e'(sel);
    assign w_accept    = in_valid & r_in_ready;
    assign w_mul_start = w_accept & (w_op == OP_MUL);

    assign w_a_ext = {a[WIDTH-1], a};
    assign w_b_ext = {b[WIDTH-1], b};

    always_comb begin
        w_wide = w_a_ext + w_b_ext;
        case (w_op)
            OP_SUB:  w_wide = w_a_ext - w_b_ext;
            OP_NEG:  w_wide = -w_a_ext;
            default: w_wide = w_a_ext + w_b_ext;
        endcase
    end

    // One guard bit suffices: overflow shows as the top two bits disagreeing.
    assign w_fast_q  = w_wide[WIDTH-1:0];
    assign w_fast_ov = w_wide[WIDTH] ^ w_wide[WIDTH-1];

    arith_seq_mul #(
        .WIDTH   (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (w_mul_start),
        .a       (a),
        .b       (b),
        .done    (w_mul_done),
        .product (w_prod)
    );

    assign w_prod_hi = w_prod[2*WIDTH-1:WIDTH-1];
    assign w_mul_ov  = ~((&w_prod_hi) | ~(|w_prod_hi));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = (w_op == OP_MUL) ? ST_BUSY : ST_DONE;
                end
            end
            ST_BUSY: begin
                if (w_mul_done) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Handshake flags are decoded from the next state so both are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_q         <= '0;
            r_ov        <= 1'b0;
        end else begin
            r_in_ready  <= (w_next == ST_IDLE);
            r_out_valid <= (w_next == ST_DONE);
            if (w_accept && (w_op != OP_MUL)) begin
                r_q  <= w_fast_q;
                r_ov <= w_fast_ov;
            end else if ((r_state == ST_BUSY) && w_mul_done) begin
                r_q  <= w_prod[WIDTH-1:0];
                r_ov <= w_mul_ov;
            end
        end
    end

`ifdef ARITH_OVF_COUNT_EN
    logic [OVF_CNT_W-1:0] r_ovf_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_cnt <= '0;
        end else if (r_out_valid && out_ready && r_ov) begin
            r_ovf_cnt <= sat_inc(r_ovf_cnt);
        end
    end

    assign ovf_count = r_ovf_cnt;
`endif

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign q         = r_q;
    assign overflow  = r_ov;

endmodule
`default_nettype wire
